// File: rtl/pps_clock_pkg.sv
// Shared BCD limits, time record and digit helpers for the PPS time-of-day clock.
`default_nettype none

package pps_clock_pkg;

  localparam logic [7:0] BCD_00 = 8'h00;
  localparam logic [7:0] BCD_01 = 8'h01;
  localparam logic [7:0] BCD_11 = 8'h11;
  localparam logic [7:0] BCD_12 = 8'h12;
  localparam logic [7:0] BCD_23 = 8'h23;
  localparam logic [7:0] BCD_59 = 8'h59;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
  } bcd_time_t;

  // Two-digit BCD increment with no range wrap; callers handle their own limits.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic bcd_digits_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pps_clock_bcd_counter.sv
// bcd_mod_counter: two-digit BCD counter over MIN_VAL..MAX_VAL with load and carry.
`default_nettype none

module bcd_mod_counter
  import pps_clock_pkg::*;
#(
  parameter logic [7:0] MIN_VAL = BCD_00,
  parameter logic [7:0] MAX_VAL = BCD_59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       carry
);

  // Carry is combinational so the next stage advances on the same edge.
  assign carry = en && (value == MAX_VAL);

  always_ff @(posedge clk) begin
    if (reset)      value <= MIN_VAL;
    else if (load)  value <= load_val;
    else if (en)    value <= carry ? MIN_VAL : bcd_inc(value);
  end

endmodule

`default_nettype wire

// File: rtl/pps_clock_bcd.sv
// pps_clock_bcd: BCD hh:mm:ss clock advanced by a 1 Hz strobe, with validated load and PPS watchdog.
// Define PPS_CLOCK_12H_EN for the 12 h (01..12 + pm) build; default is 24 h.
`default_nettype none

module pps_clock_bcd
  import pps_clock_pkg::*;
#(
  parameter logic [31:0] PPS_TIMEOUT = 32'd55_000_000
) (
  input  logic       clk_50m,
  input  logic       reset,
  input  logic       pps,
  input  logic       set_valid,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  input  logic       set_pm,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       tick_min,
  output logic       tick_hour,
  output logic       day_wrap,
  output logic       set_err,
  output logic       time_valid,
  output logic       pps_lost
);

`ifdef PPS_CLOCK_12H_EN
  localparam bit TWELVE_H = 1'b1;
`else
  localparam bit TWELVE_H = 1'b0;
`endif

  localparam logic [7:0] HH_RESET = TWELVE_H ? BCD_12 : BCD_00;

  bcd_time_t   set_time;
  logic        fields_ok;
  logic        load_ok;
  logic        tick;
  logic        carry_ss;
  logic        carry_mm;
  logic        hour_wrap;
  logic [7:0]  hh_next;
  logic [31:0] wd_cnt;
  logic [31:0] wd_next;

  assign set_time = {set_hh, set_mm, set_ss};

  always_comb begin
    fields_ok = bcd_digits_ok(set_time.hh) && bcd_digits_ok(set_time.mm) &&
                bcd_digits_ok(set_time.ss) &&
                (set_time.mm <= BCD_59) && (set_time.ss <= BCD_59);
    if (TWELVE_H) fields_ok = fields_ok && (set_time.hh >= BCD_01) && (set_time.hh <= BCD_12);
    else          fields_ok = fields_ok && (set_time.hh <= BCD_23);
  end

  // Any load request, good or bad, swallows a coincident pps.
  assign load_ok = set_valid && fields_ok;
  assign tick    = pps && !set_valid;

  bcd_mod_counter #(.MIN_VAL(BCD_00), .MAX_VAL(BCD_59)) u_ss (
    .clk      (clk_50m),
    .reset    (reset),
    .en       (tick),
    .load     (load_ok),
    .load_val (set_time.ss),
    .value    (ss),
    .carry    (carry_ss)
  );

  bcd_mod_counter #(.MIN_VAL(BCD_00), .MAX_VAL(BCD_59)) u_mm (
    .clk      (clk_50m),
    .reset    (reset),
    .en       (carry_ss),
    .load     (load_ok),
    .load_val (set_time.mm),
    .value    (mm),
    .carry    (carry_mm)
  );

  always_comb begin
    hh_next   = hh;
    hour_wrap = 1'b0;
    if (carry_mm) begin
      if (TWELVE_H) begin
        if (hh == BCD_11) begin
          hh_next   = BCD_12;
          hour_wrap = pm;
        end else if (hh == BCD_12) begin
          hh_next = BCD_01;
        end else begin
          hh_next = bcd_inc(hh);
        end
      end else begin
        if (hh == BCD_23) begin
          hh_next   = BCD_00;
          hour_wrap = 1'b1;
        end else begin
          hh_next = bcd_inc(hh);
        end
      end
    end
  end

  always_ff @(posedge clk_50m) begin
    if (reset)        hh <= HH_RESET;
    else if (load_ok) hh <= set_time.hh;
    else              hh <= hh_next;
  end

`ifdef PPS_CLOCK_12H_EN
  // pm flips on the 11 -> 12 transition in both directions.
  always_ff @(posedge clk_50m) begin
    if (reset)                          pm <= 1'b0;
    else if (load_ok)                   pm <= set_pm;
    else if (carry_mm && hh == BCD_11)  pm <= ~pm;
  end
`else
  logic unused_set_pm;
  assign unused_set_pm = set_pm;
  assign pm = 1'b0;
`endif

  always_ff @(posedge clk_50m) begin
    if (reset) begin
      tick_min   <= 1'b0;
      tick_hour  <= 1'b0;
      day_wrap   <= 1'b0;
      set_err    <= 1'b0;
      time_valid <= 1'b0;
    end else begin
      tick_min  <= carry_ss;
      tick_hour <= carry_mm;
      day_wrap  <= hour_wrap;
      set_err   <= set_valid && !fields_ok;
      if (load_ok) time_valid <= 1'b1;
    end
  end

  always_comb begin
    wd_next = wd_cnt;
    if (pps)                        wd_next = 32'd0;
    else if (wd_cnt != PPS_TIMEOUT) wd_next = wd_cnt + 32'd1;
  end

  always_ff @(posedge clk_50m) begin
    if (reset) begin
      wd_cnt   <= 32'd0;
      pps_lost <= 1'b0;
    end else begin
      wd_cnt   <= wd_next;
      pps_lost <= (wd_next == PPS_TIMEOUT);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pps_clock_bcd.sv
// Self-checking bench for pps_clock_bcd: vector table plus directed multi-cycle sequences.
`default_nettype none

module tb_pps_clock_bcd;

`ifdef PPS_CLOCK_12H_EN
  localparam logic [7:0] HH_RST = 8'h12;
`else
  localparam logic [7:0] HH_RST = 8'h00;
`endif

  logic       clk_50m = 1'b0;
  logic       reset, pps, set_valid, set_pm;
  logic [7:0] set_hh, set_mm, set_ss;
  logic [7:0] hh, mm, ss;
  logic       pm, tick_min, tick_hour, day_wrap, set_err, time_valid, pps_lost;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_50m = ~clk_50m;

  pps_clock_bcd #(.PPS_TIMEOUT(32'd100)) dut (
    .clk_50m    (clk_50m),
    .reset      (reset),
    .pps        (pps),
    .set_valid  (set_valid),
    .set_hh     (set_hh),
    .set_mm     (set_mm),
    .set_ss     (set_ss),
    .set_pm     (set_pm),
    .hh         (hh),
    .mm         (mm),
    .ss         (ss),
    .pm         (pm),
    .tick_min   (tick_min),
    .tick_hour  (tick_hour),
    .day_wrap   (day_wrap),
    .set_err    (set_err),
    .time_valid (time_valid),
    .pps_lost   (pps_lost)
  );

  typedef struct {
    logic        sv;
    logic        p;
    logic [23:0] set_t;
    logic [23:0] exp_t;
    logic        err;
    logic [2:0]  ticks;
  } vec_t;

  vec_t vecs[14];

  task automatic cyc();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [23:0] t, input logic p_m, input logic with_pps);
    set_valid = 1'b1;
    {set_hh, set_mm, set_ss} = t;
    set_pm = p_m;
    pps = with_pps;
    cyc();
    set_valid = 1'b0;
    pps = 1'b0;
  endtask

  task automatic one_pps();
    pps = 1'b1;
    cyc();
    pps = 1'b0;
  endtask

  function automatic logic [23:0] now_t();
    return {hh, mm, ss};
  endfunction

  function automatic logic [23:0] strobes();
    return 24'({day_wrap, tick_hour, tick_min});
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int sec;
    int ticks_seen;
    int c;
    logic [7:0] exp_ss;

    vecs[0]  = '{1'b1, 1'b1, 24'h102030, 24'h102030, 1'b0, 3'b000};
    vecs[1]  = '{1'b0, 1'b1, 24'h000000, 24'h102031, 1'b0, 3'b000};
    vecs[2]  = '{1'b1, 1'b0, 24'h095959, 24'h095959, 1'b0, 3'b000};
    vecs[3]  = '{1'b0, 1'b1, 24'h000000, 24'h100000, 1'b0, 3'b011};
    vecs[4]  = '{1'b1, 1'b0, 24'h105A00, 24'h100000, 1'b1, 3'b000};
    vecs[5]  = '{1'b1, 1'b0, 24'h126000, 24'h100000, 1'b1, 3'b000};
    vecs[6]  = '{1'b1, 1'b0, 24'h120060, 24'h100000, 1'b1, 3'b000};
    vecs[7]  = '{1'b0, 1'b0, 24'h000000, 24'h100000, 1'b0, 3'b000};
    vecs[8]  = '{1'b1, 1'b0, 24'h010259, 24'h010259, 1'b0, 3'b000};
    vecs[9]  = '{1'b0, 1'b1, 24'h000000, 24'h010300, 1'b0, 3'b001};
    vecs[10] = '{1'b1, 1'b0, 24'h1A0000, 24'h010300, 1'b1, 3'b000};
    vecs[11] = '{1'b1, 1'b1, 24'h0B0000, 24'h010300, 1'b1, 3'b000};
    vecs[12] = '{1'b1, 1'b0, 24'h111111, 24'h111111, 1'b0, 3'b000};
    vecs[13] = '{1'b0, 1'b1, 24'h000000, 24'h111112, 1'b0, 3'b000};

    reset = 1'b1; pps = 1'b0; set_valid = 1'b0; set_pm = 1'b0;
    set_hh = 8'h00; set_mm = 8'h00; set_ss = 8'h00;
    cyc(); cyc();
    reset = 1'b0;

    chk("reset_time", now_t(), {HH_RST, 16'h0000});
    chk("reset_pm", 24'(pm), 24'd0);
    chk("reset_strobes", strobes(), 24'd0);
    chk("reset_set_err", 24'(set_err), 24'd0);
    chk("reset_time_valid", 24'(time_valid), 24'd0);
    chk("reset_pps_lost", 24'(pps_lost), 24'd0);

    // 61 pulses with idle gaps: seconds roll once, minute carries once.
    sec = 0; ticks_seen = 0;
    for (int i = 0; i < 61; i++) begin
      one_pps();
      sec = (sec + 1) % 60;
      exp_ss = 8'(((sec / 10) << 4) | (sec % 10));
      if (tick_min) ticks_seen++;
      chk("count_ss", 24'(ss), 24'(exp_ss));
      cyc();
      if (tick_min) ticks_seen++;
    end
    chk("count_tick_min_pulses", 24'(ticks_seen), 24'd1);
    chk("count_time", now_t(), {HH_RST, 16'h0101});

    // Rejected loads before any good load.
    load(24'h240000, 1'b0, 1'b0);
    chk("bad24_err", 24'(set_err), 24'd1);
    chk("bad24_time", now_t(), {HH_RST, 16'h0101});
    load(24'h005A00, 1'b0, 1'b0);
    chk("bad5A_err", 24'(set_err), 24'd1);
    chk("bad5A_time", now_t(), {HH_RST, 16'h0101});
    chk("bad_time_valid", 24'(time_valid), 24'd0);

    for (int i = 0; i < 14; i++) begin
      set_valid = vecs[i].sv;
      pps = vecs[i].p;
      set_pm = 1'b0;
      {set_hh, set_mm, set_ss} = vecs[i].set_t;
      cyc();
      set_valid = 1'b0;
      pps = 1'b0;
      chk($sformatf("vec%0d_time", i), now_t(), vecs[i].exp_t);
      chk($sformatf("vec%0d_err", i), 24'(set_err), 24'(vecs[i].err));
      chk($sformatf("vec%0d_strobes", i), strobes(), 24'(vecs[i].ticks));
    end
    chk("time_valid_after_load", 24'(time_valid), 24'd1);

`ifdef PPS_CLOCK_12H_EN
    load(24'h115959, 1'b0, 1'b0);
    one_pps();
    chk("am_to_pm_time", now_t(), 24'h120000);
    chk("am_to_pm_pm", 24'(pm), 24'd1);
    chk("am_to_pm_strobes", strobes(), 24'h000003);
    load(24'h125959, 1'b1, 1'b0);
    one_pps();
    chk("12_to_01_time", now_t(), 24'h010000);
    chk("12_to_01_pm", 24'(pm), 24'd1);
    load(24'h115959, 1'b1, 1'b0);
    one_pps();
    chk("day12_time", now_t(), 24'h120000);
    chk("day12_pm", 24'(pm), 24'd0);
    chk("day12_strobes", strobes(), 24'h000007);
    load(24'h000000, 1'b0, 1'b0);
    chk("hh00_rejected", 24'(set_err), 24'd1);
    chk("hh00_time", now_t(), 24'h120000);
`else
    load(24'h235958, 1'b1, 1'b0);
    chk("load_235958", now_t(), 24'h235958);
    chk("pm_tied_low", 24'(pm), 24'd0);
    one_pps();
    chk("wrap_step1_time", now_t(), 24'h235959);
    chk("wrap_step1_strobes", strobes(), 24'd0);
    one_pps();
    chk("wrap_time", now_t(), 24'h000000);
    chk("wrap_strobes", strobes(), 24'h000007);
    cyc();
    chk("wrap_strobes_one_cycle", strobes(), 24'd0);
`endif

    // Reset wins over a coincident pps and load.
    reset = 1'b1;
    load(24'h050505, 1'b1, 1'b1);
    reset = 1'b0;
    chk("midreset_time", now_t(), {HH_RST, 16'h0000});
    chk("midreset_time_valid", 24'(time_valid), 24'd0);
    chk("midreset_strobes", strobes(), 24'd0);

    // Watchdog: rise exactly 100 cycles after the last pps, hold, then clear.
    one_pps();
    chk("wd_after_pps", 24'(pps_lost), 24'd0);
    c = 0;
    while (c < 200 && !pps_lost) begin
      cyc();
      c++;
    end
    chk("wd_rise_cycles", 24'(c), 24'd100);
    repeat (20) cyc();
    chk("wd_saturated_hold", 24'(pps_lost), 24'd1);
    one_pps();
    chk("wd_clear", 24'(pps_lost), 24'd0);
    repeat (99) cyc();
    chk("wd_restart_99", 24'(pps_lost), 24'd0);
    cyc();
    chk("wd_restart_100", 24'(pps_lost), 24'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
